// File: rtl/mcu_spi_slave_pkg.sv
// Shared constants and FSM state type for the MCU-facing SPI register slave.
package mcu_spi_slave_pkg;

    localparam int unsigned ADDR_W          = 7;
    localparam int unsigned CMD_DIR_BIT     = 7;
    localparam logic [7:0]  ID_BYTE_DEFAULT = 8'h5A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/mcu_spi_slave_if.sv
// SPI pins plus the register-space bus between the SPI slave and the register file.
interface mcu_spi_slave_if;
    import mcu_spi_slave_pkg::*;

    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              active;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, active
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd, active
    );

endinterface

// File: rtl/mcu_spi_slave_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the last two synced samples.
module mcu_spi_slave_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk28,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk28) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    always_comb begin
        out  = chain[SYNC_STAGES-1];
        rise = out && !prev;
        fall = !out && prev;
    end

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave giving the board MCU byte access to a 128-entry register space.
// SCK, CS_N and MOSI are oversampled in clk28; byte 0 carries direction and start address.
module mcu_spi_slave
    import mcu_spi_slave_pkg::*;
#(
    parameter logic [7:0]  ID_BYTE     = ID_BYTE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk28,
    input  logic           rst,
    mcu_spi_slave_if.slave bus
);
    state_t state, state_nxt;

    logic                   sck_level_unused, sck_rise, sck_fall;
    logic                   cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;

    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sh;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_sh;
    logic [ADDR_W-1:0] addr;
    logic              dir_wr;
    logic              armed;
    logic              rd_q;
    logic              reg_wr_q, reg_rd_q;
    logic [7:0]        reg_wdata_q;

    logic in_frame, start, abort, shift_in, shift_out, byte_done;
    logic active_c, miso_c;

    mcu_spi_slave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_sck_sync (
        .clk28(clk28),
        .rst  (rst),
        .in   (bus.spi_sck),
        .out  (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // CS_N chain resets low and 'armed' waits for a synced high, so a frame
    // already running when reset releases never produces a start.
    mcu_spi_slave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_cs_sync (
        .clk28(clk28),
        .rst  (rst),
        .in   (bus.spi_cs_n),
        .out  (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk28) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.spi_mosi};
        end
    end

    always_comb begin
        mosi_s    = mosi_chain[SYNC_STAGES-1];
        in_frame  = (state != IDLE);
        start     = (state == IDLE) && cs_fall && armed;
        abort     = in_frame && cs_rise;
        shift_in  = in_frame && sck_rise;
        byte_done = shift_in && (bit_cnt == 3'd7);
        shift_out = in_frame && sck_fall && (bit_cnt != 3'd0);
        rx_byte   = {rx_sh, mosi_s};
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CMD;
            CMD: begin
                if (cs_rise)        state_nxt = IDLE;
                else if (byte_done) state_nxt = DATA;
            end
            DATA: if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active_c = armed && !cs_sync;
        miso_c   = active_c ? tx_sh[7] : 1'b1;
    end

    // The fall after a byte's 8th rise does not shift: tx already holds the
    // next byte (ID or prefetched read data) with its MSB on MISO.
    always_ff @(posedge clk28) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= ID_BYTE;
            addr        <= '0;
            dir_wr      <= 1'b0;
            armed       <= 1'b0;
            rd_q        <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_wdata_q <= '0;
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            rd_q     <= reg_rd_q;
            if (cs_sync) armed <= 1'b1;

            if (start || abort) begin
                bit_cnt <= '0;
                tx_sh   <= ID_BYTE;
            end else begin
                if (shift_in) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sh   <= rx_byte[6:0];
                end
                if (shift_out) tx_sh <= {tx_sh[6:0], 1'b1};
                if (rd_q && in_frame) tx_sh <= bus.reg_rdata;
            end

            // Strobes still fire when CS_N rises in the same cycle as the 8th rise.
            if (byte_done) begin
                if (state == CMD) begin
                    addr     <= rx_byte[ADDR_W-1:0];
                    dir_wr   <= rx_byte[CMD_DIR_BIT];
                    reg_rd_q <= !rx_byte[CMD_DIR_BIT];
                end else if (dir_wr) begin
                    reg_wr_q    <= 1'b1;
                    reg_wdata_q <= rx_byte;
                end else begin
                    addr     <= addr + 1'b1;
                    reg_rd_q <= 1'b1;
                end
            end
            if (reg_wr_q) addr <= addr + 1'b1;
        end
    end

    assign bus.active      = active_c;
    assign bus.spi_miso_oe = active_c;
    assign bus.spi_miso    = miso_c;
    assign bus.reg_addr    = addr;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_rd      = reg_rd_q;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed bench for mcu_spi_slave: MCU-side SPI master driver plus a register-file model.
`timescale 1ns/1ps
module tb_mcu_spi_slave;

    logic        clk28 = 1'b0;
    logic        rst;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned both_cnt = 0;

    logic [14:0] wr_log[$];
    logic [6:0]  rd_log[$];

    mcu_spi_slave_if bus();

    mcu_spi_slave #(
        .ID_BYTE    (8'h5A),
        .SYNC_STAGES(2)
    ) dut (
        .clk28(clk28),
        .rst  (rst),
        .bus  (bus)
    );

    always #18 clk28 = ~clk28;

    // Register file: read data is addr + 8'h40, valid only on the cycle after reg_rd.
    always @(posedge clk28)
        bus.reg_rdata <= bus.reg_rd ? (8'h40 + {1'b0, bus.reg_addr}) : 8'h00;

    always @(negedge clk28) begin
        if (bus.reg_wr) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.reg_rd) rd_log.push_back(bus.reg_addr);
        if (bus.reg_wr && bus.reg_rd) both_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk28);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit cs_on_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            clks(4);
            rx[i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            if (cs_on_last && i == 0) bus.spi_cs_n = 1'b1;
            clks(4);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low;
        bus.spi_cs_n = 1'b0;
        clks(4);
    endtask

    task automatic cs_high;
        clks(4);
        bus.spi_cs_n = 1'b1;
        clks(10);
    endtask

    task automatic clear_logs;
        wr_log.delete();
        rd_log.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clks(3);
        n_cmp++; if (bus.spi_miso !== 1'b1) begin n_err++; $display("FAIL reset_miso got %b exp 1", bus.spi_miso); end
        n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b exp 0", bus.spi_miso_oe); end
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b exp 0", bus.active); end
        n_cmp++; if (bus.reg_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b exp 0", bus.reg_wr); end
        n_cmp++; if (bus.reg_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b exp 0", bus.reg_rd); end
        n_cmp++; if (bus.reg_addr !== 7'h00) begin n_err++; $display("FAIL reset_addr got %h exp 00", bus.reg_addr); end
        n_cmp++; if (bus.reg_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got %h exp 00", bus.reg_wdata); end
        rst = 1'b0;
        clks(6);
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL post_reset_active got %b exp 0", bus.active); end
    endtask

    task automatic test_write;
        logic [7:0] rx0, rxd;
        logic [14:0] w0, w1;
        clear_logs();
        cs_low();
        n_cmp++; if (bus.active !== 1'b1) begin n_err++; $display("FAIL write_active got %b exp 1", bus.active); end
        n_cmp++; if (bus.spi_miso_oe !== 1'b1) begin n_err++; $display("FAIL write_oe got %b exp 1", bus.spi_miso_oe); end
        spi_xfer(8'h85, 8, 1'b0, rx0);
        spi_xfer(8'h11, 8, 1'b0, rxd);
        spi_xfer(8'h22, 8, 1'b0, rxd);
        cs_high();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 15'h7FFF;
        w1 = (wr_log.size() > 1) ? wr_log[1] : 15'h7FFF;
        n_cmp++; if (rx0 !== 8'h5A) begin n_err++; $display("FAIL write_miso_id got %h exp 5a", rx0); end
        n_cmp++; if (wr_log.size() !== 2) begin n_err++; $display("FAIL write_count got %0d exp 2", wr_log.size()); end
        n_cmp++; if (w0 !== {7'h05, 8'h11}) begin n_err++; $display("FAIL write_0 got addr %h data %h exp 05/11", w0[14:8], w0[7:0]); end
        n_cmp++; if (w1 !== {7'h06, 8'h22}) begin n_err++; $display("FAIL write_1 got addr %h data %h exp 06/22", w1[14:8], w1[7:0]); end
        n_cmp++; if (rd_log.size() !== 0) begin n_err++; $display("FAIL write_no_rd got %0d exp 0", rd_log.size()); end
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL write_end_active got %b exp 0", bus.active); end
    endtask

    task automatic test_read;
        logic [7:0] rx0, rx1, rx2;
        logic [6:0] r0, r1, r2;
        clear_logs();
        cs_low();
        spi_xfer(8'h10, 8, 1'b0, rx0);
        spi_xfer(8'h00, 8, 1'b0, rx1);
        spi_xfer(8'h00, 8, 1'b0, rx2);
        cs_high();
        r0 = (rd_log.size() > 0) ? rd_log[0] : 7'h7F;
        r1 = (rd_log.size() > 1) ? rd_log[1] : 7'h7F;
        r2 = (rd_log.size() > 2) ? rd_log[2] : 7'h7F;
        n_cmp++; if (rx0 !== 8'h5A) begin n_err++; $display("FAIL read_miso0 got %h exp 5a", rx0); end
        n_cmp++; if (rx1 !== 8'h50) begin n_err++; $display("FAIL read_miso1 got %h exp 50", rx1); end
        n_cmp++; if (rx2 !== 8'h51) begin n_err++; $display("FAIL read_miso2 got %h exp 51", rx2); end
        n_cmp++; if (rd_log.size() !== 3) begin n_err++; $display("FAIL read_count got %0d exp 3", rd_log.size()); end
        n_cmp++; if (r0 !== 7'h10) begin n_err++; $display("FAIL read_addr0 got %h exp 10", r0); end
        n_cmp++; if (r1 !== 7'h11) begin n_err++; $display("FAIL read_addr1 got %h exp 11", r1); end
        n_cmp++; if (r2 !== 7'h12) begin n_err++; $display("FAIL read_prefetch got %h exp 12", r2); end
        n_cmp++; if (wr_log.size() !== 0) begin n_err++; $display("FAIL read_no_wr got %0d exp 0", wr_log.size()); end
    endtask

    task automatic test_wrap;
        logic [7:0] rxd;
        logic [14:0] w0, w1;
        clear_logs();
        cs_low();
        spi_xfer(8'hFF, 8, 1'b0, rxd);
        spi_xfer(8'hAA, 8, 1'b0, rxd);
        spi_xfer(8'hBB, 8, 1'b0, rxd);
        cs_high();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 15'h0000;
        w1 = (wr_log.size() > 1) ? wr_log[1] : 15'h0000;
        n_cmp++; if (wr_log.size() !== 2) begin n_err++; $display("FAIL wrap_count got %0d exp 2", wr_log.size()); end
        n_cmp++; if (w0 !== {7'h7F, 8'hAA}) begin n_err++; $display("FAIL wrap_0 got addr %h data %h exp 7f/aa", w0[14:8], w0[7:0]); end
        n_cmp++; if (w1 !== {7'h00, 8'hBB}) begin n_err++; $display("FAIL wrap_1 got addr %h data %h exp 00/bb", w1[14:8], w1[7:0]); end
    endtask

    task automatic test_abort;
        logic [7:0] rx0, rxd;
        logic [14:0] w0;
        clear_logs();
        cs_low();
        spi_xfer(8'h85, 8, 1'b0, rxd);
        spi_xfer(8'hC3, 5, 1'b0, rxd);
        cs_high();
        n_cmp++; if (wr_log.size() !== 0) begin n_err++; $display("FAIL abort_no_wr got %0d exp 0", wr_log.size()); end
        cs_low();
        spi_xfer(8'h83, 8, 1'b0, rx0);
        spi_xfer(8'h44, 8, 1'b0, rxd);
        cs_high();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 15'h7FFF;
        n_cmp++; if (rx0 !== 8'h5A) begin n_err++; $display("FAIL abort_next_miso got %h exp 5a", rx0); end
        n_cmp++; if (wr_log.size() !== 1) begin n_err++; $display("FAIL abort_next_count got %0d exp 1", wr_log.size()); end
        n_cmp++; if (w0 !== {7'h03, 8'h44}) begin n_err++; $display("FAIL abort_next_wr got addr %h data %h exp 03/44", w0[14:8], w0[7:0]); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx0, rxd;
        logic [14:0] w0;
        clear_logs();
        cs_low();
        spi_xfer(8'h85, 8, 1'b0, rxd);
        spi_xfer(8'h99, 4, 1'b0, rxd);
        rst = 1'b1;
        clks(1);
        n_cmp++; if (bus.spi_miso !== 1'b1) begin n_err++; $display("FAIL rstmid_miso got %b exp 1", bus.spi_miso); end
        n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe got %b exp 0", bus.spi_miso_oe); end
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL rstmid_active got %b exp 0", bus.active); end
        n_cmp++; if (bus.reg_addr !== 7'h00) begin n_err++; $display("FAIL rstmid_addr got %h exp 00", bus.reg_addr); end
        clks(1);
        rst = 1'b0;
        spi_xfer(8'h99, 4, 1'b0, rxd);
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL rstmid_wait_fall got %b exp 0", bus.active); end
        cs_high();
        n_cmp++; if (wr_log.size() + rd_log.size() !== 0) begin n_err++; $display("FAIL rstmid_no_strobe got %0d exp 0", wr_log.size() + rd_log.size()); end
        cs_low();
        spi_xfer(8'h86, 8, 1'b0, rx0);
        spi_xfer(8'h77, 8, 1'b0, rxd);
        cs_high();
        w0 = (wr_log.size() > 0) ? wr_log[0] : 15'h7FFF;
        n_cmp++; if (rx0 !== 8'h5A) begin n_err++; $display("FAIL rstmid_next_miso got %h exp 5a", rx0); end
        n_cmp++; if (wr_log.size() !== 1) begin n_err++; $display("FAIL rstmid_next_count got %0d exp 1", wr_log.size()); end
        n_cmp++; if (w0 !== {7'h06, 8'h77}) begin n_err++; $display("FAIL rstmid_next_wr got addr %h data %h exp 06/77", w0[14:8], w0[7:0]); end
    endtask

    task automatic test_noise;
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            bus.spi_mosi = i[0];
            clks(4);
            bus.spi_sck = ~bus.spi_sck;
            if (i == 9) begin
                n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL noise_active got %b exp 0", bus.active); end
                n_cmp++; if (bus.spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL noise_oe got %b exp 0", bus.spi_miso_oe); end
            end
        end
        clks(8);
        n_cmp++; if (wr_log.size() + rd_log.size() !== 0) begin n_err++; $display("FAIL noise_no_strobe got %0d exp 0", wr_log.size() + rd_log.size()); end
        n_cmp++; if (bus.spi_miso !== 1'b1) begin n_err++; $display("FAIL noise_miso got %b exp 1", bus.spi_miso); end
    endtask

    task automatic test_cs_with_last_rise;
        logic [7:0] rxd;
        logic [14:0] w0;
        clear_logs();
        cs_low();
        spi_xfer(8'hA0, 8, 1'b0, rxd);
        spi_xfer(8'h33, 8, 1'b1, rxd);
        clks(10);
        w0 = (wr_log.size() > 0) ? wr_log[0] : 15'h7FFF;
        n_cmp++; if (wr_log.size() !== 1) begin n_err++; $display("FAIL cslast_count got %0d exp 1", wr_log.size()); end
        n_cmp++; if (w0 !== {7'h20, 8'h33}) begin n_err++; $display("FAIL cslast_wr got addr %h data %h exp 20/33", w0[14:8], w0[7:0]); end
        n_cmp++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL cslast_active got %b exp 0", bus.active); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_noise();
        test_cs_with_last_rise();
        n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL wr_rd_overlap got %0d exp 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
